// File: rtl/tl_tx_tag_tracker.sv
// Non-posted tag allocator with per-tag outstanding bitmap, completion retire and timeout.
// Grant is combinational (zero latency, withheld while full); error pulses and counts are registered, one cycle later.
module tl_tx_tag_tracker #(
    parameter int REQUESTER_ID_WIDTH  = 16,
    parameter int REQUESTER_TAG_WIDTH = 10,
    parameter int TAG_WIDTH           = 5,
    parameter int TO_WIDTH            = 4,
    parameter int PRESCALE            = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQUESTER_ID_WIDTH-1:0]  cfg_req_id,
    input  logic                           tag_req,
    output logic                           tag_gnt,
    output logic [REQUESTER_TAG_WIDTH-1:0] tag_out,
    input  logic                           cpl_valid,
    input  logic [REQUESTER_ID_WIDTH-1:0]  cpl_req_id,
    input  logic [REQUESTER_TAG_WIDTH-1:0] cpl_tag,
    input  logic                           cpl_last,
    input  logic                           uc_en,
    output logic                           uc_error,
    output logic [REQUESTER_TAG_WIDTH-1:0] uc_tag,
    output logic                           to_error,
    output logic [REQUESTER_TAG_WIDTH-1:0] to_tag,
    output logic [TAG_WIDTH:0]             outstanding_cnt,
    output logic                           full,
    output logic                           empty
);
    localparam int NUM_TAGS = 2**TAG_WIDTH;
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TO_WIDTH-1:0] AGE_MAX = '1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);

    logic [NUM_TAGS-1:0]  busy;
    logic [TO_WIDTH-1:0]  age [NUM_TAGS];
    logic [PS_W-1:0]      presc;
    logic [TAG_WIDTH:0]   cnt_next;
    logic [TAG_WIDTH-1:0] free_idx;
    logic [TAG_WIDTH-1:0] exp_idx;
    logic [TAG_WIDTH-1:0] cpl_idx;
    logic                 exp_found;
    logic                 tick;
    logic                 cpl_match;
    logic                 retire;
    logic                 expire;
    logic                 uc_hit;

    // Descending scans so the lowest qualifying index wins.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = TAG_WIDTH'(i);
        end
    end

    always_comb begin
        exp_found = 1'b0;
        exp_idx   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (busy[i] && age[i] == AGE_MAX) begin
                exp_found = 1'b1;
                exp_idx   = TAG_WIDTH'(i);
            end
        end
    end

    assign tag_gnt   = tag_req & ~full;
    assign tag_out   = REQUESTER_TAG_WIDTH'(free_idx);
    assign cpl_idx   = cpl_tag[TAG_WIDTH-1:0];
    assign cpl_match = cpl_valid && (cpl_req_id == cfg_req_id) &&
                       (cpl_tag[REQUESTER_TAG_WIDTH-1:TAG_WIDTH] == '0) && busy[cpl_idx];
    assign retire    = cpl_match & cpl_last;
    // Any matching completion on the tag about to expire rescues it.
    assign expire    = exp_found & ~(cpl_match && (cpl_idx == exp_idx));
    assign uc_hit    = cpl_valid & ~cpl_match & uc_en;
    assign tick      = (presc == PS_LAST);
    assign cnt_next  = outstanding_cnt + (TAG_WIDTH+1)'(tag_gnt)
                     - (TAG_WIDTH+1)'(retire) - (TAG_WIDTH+1)'(expire);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= '0;
            presc           <= '0;
            outstanding_cnt <= '0;
            full            <= 1'b0;
            empty           <= 1'b1;
            uc_error        <= 1'b0;
            uc_tag          <= '0;
            to_error        <= 1'b0;
            to_tag          <= '0;
            for (int i = 0; i < NUM_TAGS; i++) age[i] <= '0;
        end else begin
            presc           <= tick ? '0 : presc + PS_W'(1);
            outstanding_cnt <= cnt_next;
            full            <= (cnt_next == (TAG_WIDTH+1)'(NUM_TAGS));
            empty           <= (cnt_next == '0);
            uc_error        <= uc_hit;
            to_error        <= expire;
            if (uc_hit) uc_tag <= cpl_tag;
            if (expire) to_tag <= REQUESTER_TAG_WIDTH'(exp_idx);
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (tag_gnt && free_idx == TAG_WIDTH'(i)) begin
                    busy[i] <= 1'b1;
                    age[i]  <= '0;
                end else if (cpl_match && cpl_idx == TAG_WIDTH'(i)) begin
                    if (cpl_last) busy[i] <= 1'b0;
                    else          age[i]  <= '0;
                end else if (expire && exp_idx == TAG_WIDTH'(i)) begin
                    busy[i] <= 1'b0;
                end else if (tick && busy[i] && age[i] != AGE_MAX) begin
                    age[i] <= age[i] + TO_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tl_tx_tag_tracker.sv
// Scoreboard bench: driver pushes model predictions per cycle, negedge monitor pops and compares.
module tb_tl_tx_tag_tracker;
    localparam int IDW  = 16;
    localparam int RTW  = 10;
    localparam int TW   = 5;
    localparam int TOW  = 3;
    localparam int PS   = 8;
    localparam int NUM  = 2**TW;
    localparam int AMAX = 2**TOW - 1;
    localparam logic [IDW-1:0] CFG = 16'h0123;

    logic           clk = 1'b0;
    logic           rst;
    logic [IDW-1:0] cfg_req_id;
    logic           tag_req;
    logic           tag_gnt;
    logic [RTW-1:0] tag_out;
    logic           cpl_valid;
    logic [IDW-1:0] cpl_req_id;
    logic [RTW-1:0] cpl_tag;
    logic           cpl_last;
    logic           uc_en;
    logic           uc_error;
    logic [RTW-1:0] uc_tag;
    logic           to_error;
    logic [RTW-1:0] to_tag;
    logic [TW:0]    outstanding_cnt;
    logic           full;
    logic           empty;

    always #5 clk = ~clk;

    tl_tx_tag_tracker #(
        .REQUESTER_ID_WIDTH(IDW), .REQUESTER_TAG_WIDTH(RTW),
        .TAG_WIDTH(TW), .TO_WIDTH(TOW), .PRESCALE(PS)
    ) dut (
        .clk(clk), .rst(rst), .cfg_req_id(cfg_req_id),
        .tag_req(tag_req), .tag_gnt(tag_gnt), .tag_out(tag_out),
        .cpl_valid(cpl_valid), .cpl_req_id(cpl_req_id), .cpl_tag(cpl_tag),
        .cpl_last(cpl_last), .uc_en(uc_en),
        .uc_error(uc_error), .uc_tag(uc_tag),
        .to_error(to_error), .to_tag(to_tag),
        .outstanding_cnt(outstanding_cnt), .full(full), .empty(empty)
    );

    typedef struct {
        bit gnt; int tout;
        bit uc;  int uct;
        bit to;  int tot;
        int cnt; bit full; bit empty;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: tag table with integer ages and a cycle phase.
    bit m_known = 1'b0;
    bit m_busy [NUM];
    int m_age  [NUM];
    int m_phase, m_cnt, m_uct, m_tot;
    bit m_uc, m_to;

    function automatic int first_free();
        for (int i = 0; i < NUM; i++) if (!m_busy[i]) return i;
        return 0;
    endfunction

    function automatic int exp_cand();
        for (int i = 0; i < NUM; i++) if (m_busy[i] && m_age[i] >= AMAX) return i;
        return -1;
    endfunction

    function automatic int pick_busy();
        int t;
        t = $urandom_range(0, NUM - 1);
        for (int k = 0; k < 4; k++) begin
            if (m_busy[t]) return t;
            t = $urandom_range(0, NUM - 1);
        end
        return t;
    endfunction

    task automatic model_step(input bit r, input bit req, input bit v,
                              input logic [IDW-1:0] id, input int tag, input bit last, input bit ue);
        bit gnt, match, expire;
        int ft, ex;
        if (r) begin
            for (int i = 0; i < NUM; i++) begin m_busy[i] = 0; m_age[i] = 0; end
            m_phase = 0; m_cnt = 0; m_uc = 0; m_uct = 0; m_to = 0; m_tot = 0;
            m_known = 1'b1;
            return;
        end
        gnt    = req && (m_cnt < NUM);
        ft     = first_free();
        match  = v && (id == CFG) && (tag < NUM) && m_busy[tag];
        ex     = exp_cand();
        expire = (ex >= 0) && !(match && tag == ex);
        m_uc   = v && !match && ue;
        if (m_uc) m_uct = tag;
        m_to   = expire;
        if (expire) m_tot = ex;
        if (m_phase == PS - 1)
            for (int i = 0; i < NUM; i++)
                if (m_busy[i] && m_age[i] < AMAX) m_age[i]++;
        m_phase = (m_phase + 1) % PS;
        if (match) begin
            if (last) begin m_busy[tag] = 0; m_cnt--; end
            else m_age[tag] = 0;
        end
        if (expire) begin m_busy[ex] = 0; m_cnt--; end
        if (gnt) begin m_busy[ft] = 1; m_age[ft] = 0; m_cnt++; end
    endtask

    task automatic cyc(input bit r, input bit req, input bit v, input logic [IDW-1:0] id,
                       input int tag, input bit last, input bit ue);
        exp_t e;
        rst = r; tag_req = req; cpl_valid = v; cpl_req_id = id;
        cpl_tag = RTW'(tag); cpl_last = last; uc_en = ue;
        if (!r && m_known) begin
            e.gnt = req && (m_cnt < NUM); e.tout = first_free();
            e.uc = m_uc; e.uct = m_uct; e.to = m_to; e.tot = m_tot;
            e.cnt = m_cnt; e.full = (m_cnt == NUM); e.empty = (m_cnt == 0);
            sbq.push_back(e);
        end
        model_step(r, req, v, id, tag, last, ue);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, CFG, 0, 0, 1);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                check("tag_gnt",         int'(tag_gnt),         int'(e.gnt));
                check("tag_out",         int'(tag_out),         e.tout);
                check("uc_error",        int'(uc_error),        int'(e.uc));
                check("uc_tag",          int'(uc_tag),          e.uct);
                check("to_error",        int'(to_error),        int'(e.to));
                check("to_tag",          int'(to_tag),          e.tot);
                check("outstanding_cnt", int'(outstanding_cnt), e.cnt);
                check("full",            int'(full),            int'(e.full));
                check("empty",           int'(empty),           int'(e.empty));
            end
        end
    end

    initial begin
        int ex, t, k, rr;
        bit hit;
        logic [IDW-1:0] id;
        cfg_req_id = CFG;
        rst = 1'b1; tag_req = 0; cpl_valid = 0; cpl_req_id = '0;
        cpl_tag = '0; cpl_last = 0; uc_en = 0;

        // Fill all tags, then one refused request.
        cyc(1, 0, 0, CFG, 0, 0, 0);
        cyc(1, 0, 0, CFG, 0, 0, 0);
        for (int i = 0; i < NUM + 1; i++) cyc(0, 1, 0, CFG, 0, 0, 1);
        idle(2);

        // Retire tag 2 of 0..3 and regrant it.
        cyc(1, 0, 0, CFG, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, CFG, 0, 0, 1);
        cyc(0, 0, 1, CFG, 2, 1, 1);
        cyc(0, 1, 0, CFG, 0, 0, 1);
        idle(2);

        // Unexpected completions: idle tag, reporting off, wrong requester ID.
        cyc(0, 0, 1, CFG, 7, 1, 1);
        idle(2);
        cyc(0, 0, 1, CFG, 7, 1, 0);
        idle(2);
        cyc(0, 0, 1, 16'h0F0F, 1, 1, 1);
        idle(2);
        cyc(0, 0, 1, CFG, 1, 1, 1);
        idle(1);

        // Back-to-back timeouts on tags 0 and 1.
        cyc(1, 0, 0, CFG, 0, 0, 0);
        cyc(0, 1, 0, CFG, 0, 0, 1);
        cyc(0, 1, 0, CFG, 0, 0, 1);
        idle((AMAX + 1) * PS + 4);

        // Completion lands in the expiry cycle, later completion is unexpected.
        cyc(1, 0, 0, CFG, 0, 0, 0);
        cyc(0, 1, 0, CFG, 0, 0, 1);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (exp_cand() == 0) begin cyc(0, 0, 1, CFG, 0, 1, 1); hit = 1; end
            else cyc(0, 0, 0, CFG, 0, 0, 1);
        end
        check("expiry_rescue_reached", int'(hit), 1);
        idle(2);
        cyc(0, 0, 1, CFG, 0, 1, 1);
        idle(2);

        // Grant 5, retire 1 and expire 3 in a single cycle.
        cyc(1, 0, 0, CFG, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, CFG, 0, 0, 1);
        cyc(0, 0, 1, CFG, 5, 1, 1);
        hit = 0; rr = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (exp_cand() == 3) begin cyc(0, 1, 1, CFG, 1, 1, 1); hit = 1; end
            else begin
                t = (rr == 3) ? 4 : rr;
                rr = (rr + 1) % 4;
                cyc(0, 0, 1, CFG, t, 0, 1);
            end
        end
        check("triple_event_reached", int'(hit), 1);
        idle(3);

        // Randomized traffic with occasional mid-run reset.
        for (int n = 0; n < 4000; n++) begin
            bit r, req, v, last, ue;
            r    = ($urandom_range(0, 599) == 0);
            req  = ($urandom_range(0, 99) < 40);
            v    = ($urandom_range(0, 99) < 35);
            last = ($urandom_range(0, 2) != 0);
            ue   = ($urandom_range(0, 4) != 0);
            id   = ($urandom_range(0, 9) == 0) ? IDW'($urandom) : CFG;
            ex   = exp_cand();
            k    = $urandom_range(0, 9);
            if (ex >= 0 && $urandom_range(0, 1) == 1) begin
                v = 1; id = CFG; t = ex;
            end else if (k == 0) begin
                t = int'(RTW'($urandom));
            end else begin
                t = pick_busy();
            end
            cyc(r, req, v, id, t, last, ue);
        end
        idle(3);
        @(negedge clk); #1;
        check("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
